// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and helpers for the audio PWM output stage.
//   PWM_BITS  - width of the PWM counter and duty values
//   MIDSCALE  - offset-binary silence level
//   END_MARK  - reserved ROM word that marks end of track
//   GAIN_TBL  - volume index (0..10) to gain, in 1/256 units
//   bcd_to_vol_idx - two BCD digits to a volume index clamped to 0..10
package audio_pkg;

  localparam int PWM_BITS = 8;
  localparam logic [7:0] MIDSCALE = 8'd128;
  localparam logic [7:0] END_MARK = 8'h00;

  localparam logic [8:0] GAIN_TBL [0:10] = '{
    9'd0, 9'd26, 9'd51, 9'd77, 9'd102, 9'd128,
    9'd154, 9'd179, 9'd205, 9'd230, 9'd256
  };

  // Digits above 9 are treated as 9; anything above 10 is full scale.
  function automatic logic [3:0] bcd_to_vol_idx(input logic [3:0] tens,
                                                input logic [3:0] units);
    logic [3:0] t;
    logic [3:0] u;
    logic [6:0] v;
    t = (tens > 4'd9) ? 4'd9 : tens;
    u = (units > 4'd9) ? 4'd9 : units;
    v = 7'(t) * 7'd10 + 7'(u);
    return (v > 7'd10) ? 4'd10 : v[3:0];
  endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// audio_pwm_out_if: player-side signals of the audio PWM output stage.
//   play         - 1 = playing
//   sample       - current ROM word, offset binary, 0x00 = end of track
//   volume1/0    - BCD volume tens/units digits
//   sample_req   - one-cycle strobe advancing the address stage
//   end_of_track - one-cycle strobe advancing the song select
//   pwm_out      - audio pin
//   duty         - active duty value (debug)
// master drives play/sample/volume; slave is the output stage.
interface audio_pwm_out_if;

  logic       play;
  logic [7:0] sample;
  logic [3:0] volume1;
  logic [3:0] volume0;
  logic       sample_req;
  logic       end_of_track;
  logic       pwm_out;
  logic [7:0] duty;

  modport master (
    output play, sample, volume1, volume0,
    input  sample_req, end_of_track, pwm_out, duty
  );

  modport slave (
    input  play, sample, volume1, volume0,
    output sample_req, end_of_track, pwm_out, duty
  );

endinterface

// File: rtl/audio_volume_scaler.sv
// audio_volume_scaler: scales an offset-binary sample by the BCD volume.
//   clk, reset        - clock, synchronous active-high reset
//   s_reg             - latched sample word (offset binary)
//   volume1, volume0  - BCD volume digits, sampled every cycle
//   duty_next         - scaled duty, floor((s_reg-128)*gain/256)+128
// Stage 1 registers the signed product; stage 2 is the shift and offset.
module audio_volume_scaler
  import audio_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_reg,
  input  logic [3:0] volume1,
  input  logic [3:0] volume0,
  output logic [7:0] duty_next
);

  logic signed [8:0]  c;
  logic        [8:0]  gain;
  logic signed [17:0] p_d;
  logic signed [17:0] p_q;

  always_comb begin
    c    = $signed({1'b0, s_reg}) - $signed({1'b0, MIDSCALE});
    gain = GAIN_TBL[bcd_to_vol_idx(volume1, volume0)];
    p_d  = $signed({{9{c[8]}}, c}) * $signed({9'b0, gain});
  end

  // Zero product decodes to midscale, so reset leaves duty_next at 128.
  always_ff @(posedge clk) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  // Arithmetic shift floors; the result always lands in 0..255.
  assign duty_next = 8'((p_q >>> 8) + 18'sd128);

endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: per-frame sample fetch, volume scaling and PWM output.
//   clk, reset - clock, synchronous active-high reset
//   bus        - play/sample/volume in; sample_req, end_of_track,
//                pwm_out, duty out (see audio_pwm_out_if)
// PERIODS_PER_SAMPLE PWM periods of 256 clocks form one sample frame.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int PERIODS_PER_SAMPLE = 4
) (
  input  logic            clk,
  input  logic            reset,
  audio_pwm_out_if.slave  bus
);

  localparam int PER_W = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS_PER_SAMPLE - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
  logic [7:0]          s_reg_q, s_reg_d;
  logic                sample_req_q, sample_req_d;
  logic                eot_q, eot_d;
  logic [7:0]          duty_active_q, duty_active_d;
  logic                pwm_q, pwm_d;
  logic [7:0]          duty_next;
  logic                pwm_wrap;
  logic                fb;

  audio_volume_scaler u_scaler (
    .clk       (clk),
    .reset     (reset),
    .s_reg     (s_reg_q),
    .volume1   (bus.volume1),
    .volume0   (bus.volume0),
    .duty_next (duty_next)
  );

  always_comb begin
    pwm_wrap      = (pwm_cnt_q == '1);
    fb            = pwm_wrap && (per_cnt_q == PER_LAST);
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    per_cnt_d     = per_cnt_q;
    s_reg_d       = s_reg_q;
    sample_req_d  = 1'b0;
    eot_d         = 1'b0;
    duty_active_d = duty_active_q;
    pwm_d         = (pwm_cnt_q < duty_active_q);

    if (pwm_wrap) begin
      per_cnt_d     = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
      duty_active_d = duty_next;
    end

    // Paused frames play silence; the end marker itself is never played.
    if (fb) begin
      if (bus.play) begin
        sample_req_d = 1'b1;
        if (bus.sample == END_MARK) begin
          eot_d   = 1'b1;
          s_reg_d = MIDSCALE;
        end else begin
          s_reg_d = bus.sample;
        end
      end else begin
        s_reg_d = MIDSCALE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q     <= '0;
      per_cnt_q     <= '0;
      s_reg_q       <= MIDSCALE;
      sample_req_q  <= 1'b0;
      eot_q         <= 1'b0;
      duty_active_q <= MIDSCALE;
      pwm_q         <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      per_cnt_q     <= per_cnt_d;
      s_reg_q       <= s_reg_d;
      sample_req_q  <= sample_req_d;
      eot_q         <= eot_d;
      duty_active_q <= duty_active_d;
      pwm_q         <= pwm_d;
    end
  end

  assign bus.sample_req   = sample_req_q;
  assign bus.end_of_track = eot_q;
  assign bus.pwm_out      = pwm_q;
  assign bus.duty         = duty_active_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: two instances (1 and 3 PWM periods per frame) share
// one stimulus; a frame-level model is checked every cycle, and directed
// scenarios check hand-computed values.
module tb_audio_pwm_out;

  localparam int PA = 1;
  localparam int PB = 3;

  logic       clk;
  logic       reset;
  logic       play;
  logic [7:0] sample;
  logic [3:0] v1;
  logic [3:0] v0;

  int tests = 0;
  int fails = 0;

  audio_pwm_out_if bus_a ();
  audio_pwm_out_if bus_b ();

  assign bus_a.play = play;  assign bus_a.sample = sample;
  assign bus_a.volume1 = v1; assign bus_a.volume0 = v0;
  assign bus_b.play = play;  assign bus_b.sample = sample;
  assign bus_b.volume1 = v1; assign bus_b.volume0 = v0;

  audio_pwm_out #(.PERIODS_PER_SAMPLE(PA)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  audio_pwm_out #(.PERIODS_PER_SAMPLE(PB)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    bit valid;
    int n;          // clock edges since reset released
    int word;       // word for the frame in progress
    int word_snap;
    int vol_snap;
    int duty;
    bit req;
    bit eot;
    bit pwm;
  } mstate_t;

  mstate_t ms [2];

  function automatic int m_vol(input int a, input int b);
    int v;
    v = 10 * ((a > 9) ? 9 : a) + ((b > 9) ? 9 : b);
    return (v > 10) ? 10 : v;
  endfunction

  // Gain is 256*v/10 rounded to nearest.
  function automatic int m_scale(input int w, input int v);
    int p;
    int q;
    p = (w - 128) * ((256 * v + 5) / 10);
    q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    return q + 128;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input int per, input bit rst,
                                     input bit pl, input int smp, input int vidx);
    int  cnt;
    bit  fb;
    if (rst) begin
      s.valid = 1'b1; s.n = 0; s.word = 128; s.word_snap = 128; s.vol_snap = 0;
      s.duty = 128; s.req = 1'b0; s.eot = 1'b0; s.pwm = 1'b0;
      return s;
    end
    cnt = s.n % 256;
    fb  = (s.n % (256 * per)) == (256 * per - 1);
    if (cnt == 254) begin
      s.word_snap = s.word;
      s.vol_snap  = vidx;
    end
    s.pwm = (cnt < s.duty);
    if (cnt == 255) s.duty = m_scale(s.word_snap, s.vol_snap);
    s.req = fb && pl;
    s.eot = fb && pl && (smp == 0);
    if (fb) s.word = (pl && smp != 0) ? smp : 128;
    s.n++;
    return s;
  endfunction

  always @(posedge clk) begin
    ms[0] = m_step(ms[0], PA, reset, play, int'(sample), m_vol(int'(v1), int'(v0)));
    ms[1] = m_step(ms[1], PB, reset, play, int'(sample), m_vol(int'(v1), int'(v0)));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ms[0].valid) begin
      check("sb_a_req",  32'(bus_a.sample_req),   32'(ms[0].req));
      check("sb_a_eot",  32'(bus_a.end_of_track), 32'(ms[0].eot));
      check("sb_a_pwm",  32'(bus_a.pwm_out),      32'(ms[0].pwm));
      check("sb_a_duty", 32'(bus_a.duty),         32'(ms[0].duty));
    end
    if (ms[1].valid) begin
      check("sb_b_req",  32'(bus_b.sample_req),   32'(ms[1].req));
      check("sb_b_eot",  32'(bus_b.end_of_track), 32'(ms[1].eot));
      check("sb_b_pwm",  32'(bus_b.pwm_out),      32'(ms[1].pwm));
      check("sb_b_duty", 32'(bus_b.duty),         32'(ms[1].duty));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Leaves the bench in the middle of the first cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_in(input bit pl, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] smp);
    play = pl; v1 = a; v0 = b; sample = smp;
  endtask

  task automatic scale_case(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] smp, input logic [7:0] exp);
    set_in(1'b1, a, b, smp);
    do_reset();
    cyc(512);
    check({name, "_a"}, 32'(bus_a.duty), 32'(exp));
    cyc(512);
    check({name, "_b"}, 32'(bus_b.duty), 32'(exp));
  endtask

  initial begin
    int hi_a, hi_b, req_n, eot_n, lo_a;
    reset = 1'b1;
    set_in(1'b0, 4'd0, 4'd5, 8'h00);
    cyc(2);

    // Paused for four long frames, end marker on the bus
    do_reset();
    cyc(1);
    hi_a = 0; hi_b = 0; req_n = 0; eot_n = 0;
    for (int i = 0; i < 3100; i++) begin
      if (i < 1024) begin
        hi_a += int'(bus_a.pwm_out);
        hi_b += int'(bus_b.pwm_out);
      end
      req_n += int'(bus_a.sample_req) + int'(bus_b.sample_req);
      eot_n += int'(bus_a.end_of_track) + int'(bus_b.end_of_track);
      cyc(1);
    end
    check("pause_hi_a", 32'(hi_a), 32'd512);
    check("pause_hi_b", 32'(hi_b), 32'd512);
    check("pause_req",  32'(req_n), 32'd0);
    check("pause_eot",  32'(eot_n), 32'd0);
    check("pause_duty", 32'(bus_b.duty), 32'd128);

    // Full scale 0xFF, one period per frame
    set_in(1'b1, 4'd1, 4'd0, 8'hFF);
    do_reset();
    cyc(255);
    check("ff_req_c255", 32'(bus_a.sample_req), 32'd0);
    cyc(1);
    check("ff_req_c256", 32'(bus_a.sample_req), 32'd1);
    cyc(255);
    check("ff_duty_c511", 32'(bus_a.duty), 32'd128);
    cyc(1);
    check("ff_duty_c512", 32'(bus_a.duty), 32'd255);
    cyc(1);
    lo_a = 0; req_n = 0;
    for (int i = 0; i < 256; i++) begin
      lo_a  += int'(!bus_a.pwm_out);
      req_n += int'(bus_a.sample_req);
      cyc(1);
    end
    check("ff_low_cycles", 32'(lo_a), 32'd1);
    check("ff_req_per_256", 32'(req_n), 32'd1);

    scale_case("scale_v5_20", 4'd0, 4'd5, 8'h20, 8'h50);
    scale_case("scale_v3_c0", 4'd0, 4'd3, 8'hC0, 8'h93);
    scale_case("scale_v0_10", 4'd0, 4'd0, 8'h10, 8'h80);
    scale_case("scale_v15_40", 4'd1, 4'd5, 8'h40, 8'h40);
    scale_case("scale_vbad_01", 4'd12, 4'd11, 8'h01, 8'h01);

    // Volume to 00 mid-frame: current frame keeps its duty
    set_in(1'b1, 4'd1, 4'd5, 8'h40);
    do_reset();
    cyc(512);
    check("volchg_c512", 32'(bus_a.duty), 32'h40);
    cyc(88);
    v1 = 4'd0; v0 = 4'd0;
    cyc(167);
    check("volchg_c767", 32'(bus_a.duty), 32'h40);
    cyc(1);
    check("volchg_c768", 32'(bus_a.duty), 32'h80);

    // End-of-track marker while playing
    set_in(1'b1, 4'd1, 4'd0, 8'h00);
    do_reset();
    cyc(255);
    check("eot_c255", 32'(bus_a.end_of_track), 32'd0);
    cyc(1);
    check("eot_req_c256", 32'(bus_a.sample_req), 32'd1);
    check("eot_c256", 32'(bus_a.end_of_track), 32'd1);
    cyc(1);
    check("eot_c257", 32'(bus_a.end_of_track), 32'd0);
    cyc(255);
    check("eot_duty_c512", 32'(bus_a.duty), 32'd128);
    cyc(256);
    check("eot_b_req_c768", 32'(bus_b.sample_req), 32'd1);
    check("eot_b_c768", 32'(bus_b.end_of_track), 32'd1);

    // Reset mid-frame at pwm_cnt 100 with duty 255
    set_in(1'b1, 4'd1, 4'd0, 8'hFF);
    do_reset();
    cyc(612);
    check("rst_pre_duty", 32'(bus_a.duty), 32'd255);
    reset = 1'b1;
    cyc(1);
    check("rst_duty", 32'(bus_a.duty), 32'd128);
    check("rst_pwm",  32'(bus_a.pwm_out), 32'd0);
    check("rst_req",  32'(bus_a.sample_req), 32'd0);
    check("rst_eot",  32'(bus_a.end_of_track), 32'd0);
    reset = 1'b0;
    // Reset right at a frame boundary drops the pending request
    cyc(255);
    reset = 1'b1;
    cyc(1);
    check("rst_fb_req", 32'(bus_a.sample_req), 32'd0);
    reset = 1'b0;

    // play rising then falling mid-frame
    set_in(1'b0, 4'd1, 4'd0, 8'hFF);
    do_reset();
    cyc(100);
    play = 1'b1;
    cyc(156);
    check("playup_req_c256", 32'(bus_a.sample_req), 32'd1);
    cyc(44);
    play = 1'b0;
    cyc(212);
    check("playdn_req_c512", 32'(bus_a.sample_req), 32'd0);
    check("playdn_duty_c512", 32'(bus_a.duty), 32'd255);
    cyc(255);
    check("playdn_duty_c767", 32'(bus_a.duty), 32'd255);
    cyc(1);
    check("playdn_duty_c768", 32'(bus_a.duty), 32'd128);

    cyc(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
